// File: rtl/ptltx_pkg.sv
// Shared types and width helpers for the multi-lane PTL transmitter bank.
package ptltx_pkg;

    typedef enum logic [0:0] {
        ST_STARTUP,
        ST_ACTIVE
    } state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int begin_cnt_w(input int begin_cycles);
        return cnt_w(begin_cycles);
    endfunction

    function automatic int ct_cnt_w(input int ct_cycles);
        return cnt_w(ct_cycles);
    endfunction

endpackage

// File: rtl/ptltx_chan.sv
// One transition-encoded PTL lane: edge detect, critical-time guard, delay line,
// sticky violation flag and (with PTLTX_PULSE_COUNT_EN) a saturating pulse counter.
module ptltx_chan
    import ptltx_pkg::*;
#(
    parameter int LATENCY   = 3,
    parameter int CT_CYCLES = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             active,
    input  logic             a,
    input  logic             viol_clr,
    output logic             q,
    output logic             viol
`ifdef PTLTX_PULSE_COUNT_EN
    ,
    output logic [CNT_W-1:0] cnt
`endif
);

    localparam int GW = ct_cnt_w(CT_CYCLES);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("ptltx_chan: CNT_W must be >= 1");
    end

    logic          a_prev;
    logic [GW-1:0] guard;
    logic          ev;
    logic          accept;
    logic          drop;

    assign ev     = active && (a != a_prev);
    assign accept = ev && (guard == '0);
    assign drop   = ev && (guard != '0);

    // a_prev tracks a unconditionally so dropped events and startup edges resynchronise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_prev <= 1'b0;
            guard  <= '0;
            viol   <= 1'b0;
        end else begin
            a_prev <= a;
            if (accept) begin
                guard <= GW'(CT_CYCLES - 1);
            end else if (guard != '0) begin
                guard <= guard - GW'(1);
            end
            viol <= (viol & ~viol_clr) | drop;
        end
    end

    // The q flop is the last stage of the delay line, so LATENCY-1 extra stages sit before it.
    if (LATENCY == 1) begin : g_lat1
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                q <= 1'b0;
            end else begin
                q <= q ^ accept;
            end
        end
    end else begin : g_latn
        logic [LATENCY-2:0] dl;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dl <= '0;
                q  <= 1'b0;
            end else begin
                dl[0] <= accept;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    dl[i] <= dl[i-1];
                end
                q <= q ^ dl[LATENCY-2];
            end
        end
    end

`ifdef PTLTX_PULSE_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: rtl/ptltx_bank.sv
// Multi-lane PTL transmitter bank: startup hold-off FSM plus CHANNELS independent lanes.
// Optional feature macro: PTLTX_PULSE_COUNT_EN adds per-lane accepted-pulse counters.
module ptltx_bank
    import ptltx_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int LATENCY      = 3,
    parameter int CT_CYCLES    = 2,
    parameter int BEGIN_CYCLES = 8,
    parameter int CNT_W        = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       a,
    output logic [CHANNELS-1:0]       q,
    output logic                      ready,
    output logic [CHANNELS-1:0]       viol,
    input  logic                      viol_clr
`ifdef PTLTX_PULSE_COUNT_EN
    ,
    output logic [CHANNELS*CNT_W-1:0] pulse_cnt
`endif
);

    localparam int     BW        = begin_cnt_w(BEGIN_CYCLES);
    localparam state_e RST_STATE = (BEGIN_CYCLES == 0) ? ST_ACTIVE : ST_STARTUP;

    if (CHANNELS < 1) begin : g_bad_channels
        $error("ptltx_bank: CHANNELS must be >= 1");
    end
    if (LATENCY < 1) begin : g_bad_latency
        $error("ptltx_bank: LATENCY must be >= 1");
    end
    if (CT_CYCLES < 1) begin : g_bad_ct
        $error("ptltx_bank: CT_CYCLES must be >= 1");
    end
    if (BEGIN_CYCLES < 0) begin : g_bad_begin
        $error("ptltx_bank: BEGIN_CYCLES must be >= 0");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("ptltx_bank: CNT_W must be >= 1");
    end

    state_e        state;
    logic [BW-1:0] begin_cnt;
    logic          active;

    // Lanes see the pre-edge state, so the edge completing the hold-off is still ignored.
    assign active = (state == ST_ACTIVE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RST_STATE;
            begin_cnt <= '0;
            ready     <= 1'b0;
        end else begin
            case (state)
                ST_STARTUP: begin
                    if (begin_cnt == BW'(BEGIN_CYCLES - 1)) begin
                        state <= ST_ACTIVE;
                        ready <= 1'b1;
                    end else begin
                        begin_cnt <= begin_cnt + BW'(1);
                    end
                end
                ST_ACTIVE: begin
                    ready <= 1'b1;
                end
                default: begin
                    state <= RST_STATE;
                end
            endcase
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        ptltx_chan #(
            .LATENCY   (LATENCY),
            .CT_CYCLES (CT_CYCLES),
            .CNT_W     (CNT_W)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .active   (active),
            .a        (a[i]),
            .viol_clr (viol_clr),
            .q        (q[i]),
            .viol     (viol[i])
`ifdef PTLTX_PULSE_COUNT_EN
            ,
            .cnt      (pulse_cnt[i*CNT_W +: CNT_W])
`endif
        );
    end

endmodule

// File: tb/tb_ptltx_bank.sv
// Directed bench for ptltx_bank at default parameters; counter checks apply with PTLTX_PULSE_COUNT_EN.
module tb_ptltx_bank;

    localparam int CH = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] a = '0;
    logic [CH-1:0] q;
    logic          ready;
    logic [CH-1:0] viol;
    logic          viol_clr = 1'b0;
`ifdef PTLTX_PULSE_COUNT_EN
    logic [CH*CW-1:0] pulse_cnt;
`endif

    int n_checks = 0;
    int n_fails  = 0;
    int edge_no  = 0;

    ptltx_bank #(
        .CHANNELS     (CH),
        .LATENCY      (3),
        .CT_CYCLES    (2),
        .BEGIN_CYCLES (8),
        .CNT_W        (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .q         (q),
        .ready     (ready),
        .viol      (viol),
        .viol_clr  (viol_clr)
`ifdef PTLTX_PULSE_COUNT_EN
        ,
        .pulse_cnt (pulse_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle on the falling edge for checks and drives.
    task automatic step();
        @(posedge clk);
        edge_no++;
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, edge_no, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input int lane, input logic [CW-1:0] exp);
`ifdef PTLTX_PULSE_COUNT_EN
        check(tag, 64'(pulse_cnt[lane*CW +: CW]), 64'(exp));
`endif
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_q", 64'(q), 64'h0);
        check("rst_ready", 64'(ready), 64'h0);
        check("rst_viol", 64'(viol), 64'h0);
        for (int i = 0; i < CH; i++) check_cnt("rst_cnt", i, '0);

        rst = 1'b0;
        edge_no = 0;

        // Startup hold-off with lane 0/2 toggles that must be ignored.
        for (int e = 1; e <= 7; e++) begin
            step();
            check("startup_ready", 64'(ready), 64'h0);
            check("startup_q", 64'(q), 64'h0);
            check("startup_viol", 64'(viol), 64'h0);
            if (e == 1) a = 4'b0101;
            if (e == 4) a = 4'b0000;
        end
        step();
        check("ready_rise", 64'(ready), 64'h1);
        check("ready_q", 64'(q), 64'h0);
        for (int i = 0; i < CH; i++) check_cnt("startup_cnt", i, '0);

        // Lane 0: rise sampled at 12, fall at 15.
        repeat (3) step();
        a = 4'b0001;
        step();
        check("l0_e12", 64'(q), 64'h0);
        step();
        check("l0_e13", 64'(q), 64'h0);
        step();
        check("l0_e14", 64'(q), 64'h1);
        a = 4'b0000;
        step();
        check("l0_e15", 64'(q), 64'h1);
        step();
        check("l0_e16", 64'(q), 64'h1);
        step();
        check("l0_e17", 64'(q), 64'h0);
        check("l0_viol", 64'(viol), 64'h0);
        check_cnt("l0_cnt", 0, 16'd2);

        // Lane 1: toggles at 20 and 21, second one too close.
        repeat (2) step();
        a = 4'b0010;
        step();
        check("l1_e20_viol", 64'(viol), 64'h0);
        a = 4'b0000;
        step();
        check("l1_e21_viol", 64'(viol), 64'h2);
        check("l1_e21_q", 64'(q), 64'h0);
        step();
        check("l1_e22_q", 64'(q), 64'h2);
        step();
        check("l1_e23_q", 64'(q), 64'h2);
        check_cnt("l1_cnt", 1, 16'd1);

        // Lane 3: violation coincident with viol_clr, then clr alone.
        step();
        a = 4'b1000;
        step();
        a = 4'b0000;
        viol_clr = 1'b1;
        step();
        check("clr_vs_viol", 64'(viol), 64'h8);
        step();
        check("clr_alone", 64'(viol), 64'h0);
        check("l3_q", 64'(q), 64'ha);
        viol_clr = 1'b0;
        check_cnt("l3_cnt", 3, 16'd1);

        // Lane 2 accepted at 30, reset asserted before 32 discards the toggle.
        repeat (2) step();
        a = 4'b0100;
        step();
        step();
        check("l2_pending_q", 64'(q), 64'ha);
        rst = 1'b1;
        #1;
        check("async_rst_q", 64'(q), 64'h0);
        check("async_rst_ready", 64'(ready), 64'h0);
        check("async_rst_viol", 64'(viol), 64'h0);
        for (int i = 0; i < CH; i++) check_cnt("async_rst_cnt", i, '0);
        repeat (2) step();
        check("rst_hold_q", 64'(q), 64'h0);

        // Hold-off restarts after release; a stays high on lane 2 and is absorbed.
        @(negedge clk);
        rst = 1'b0;
        edge_no = 0;
        for (int e = 1; e <= 7; e++) begin
            step();
            check("restart_ready", 64'(ready), 64'h0);
            check("restart_q", 64'(q), 64'h0);
        end
        step();
        check("restart_ready_rise", 64'(ready), 64'h1);
        a = 4'b0000;
        step();
        step();
        check("restart_l2_e10", 64'(q), 64'h0);
        step();
        check("restart_l2_e11", 64'(q), 64'h4);
        check_cnt("restart_l2_cnt", 2, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/ptltx_bank.md
# ptltx_bank

Clocked, parametrised multi-channel successor to the single-channel PTL transmitter model. Each channel uses transition encoding: every input edge is one SFQ pulse, and every output edge is one transmitted pulse. The block adds four things over the single-channel model:
- a configurable delivery latency;
- a per-channel critical-time guard that drops too-close pulses and flags them;
- a startup hold-off;
- an optional pulse counter.

It sits between the logic-cell array and the PTL receiver banks in the synchronous co-simulation fabric.

## Interface
Parameters:
- CHANNELS, 4: number of independent PTL lanes (≥1)
- LATENCY, 3: clk edges from input sample to output toggle (≥1)
- CT_CYCLES, 2: minimum edge spacing between accepted pulses on one lane (≥1; 1 = no guard)
- BEGIN_CYCLES, 8: startup hold-off in clk edges after reset release (≥0)
- CNT_W, 16: pulse-counter width per lane

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- a  input  CHANNELS  transition-encoded pulse inputs
- q  output  CHANNELS  transition-encoded pulse outputs
- ready  output  1  high once startup hold-off has elapsed
- viol  output  CHANNELS  sticky critical-time violation flags
- viol_clr  input  1  synchronous clear of all viol bits
- pulse_cnt  output  CHANNELS*CNT_W  accepted-pulse counts, lane i at [i*CNT_W +: CNT_W]; present only with PTLTX_PULSE_COUNT_EN

## Operation
- Reset (asynchronous):
  - q=0, ready=0, viol=0, pulse_cnt=0.
  - Delay lines and guard counters are cleared; pending toggles are discarded.
  - a_prev is cleared to 0; state goes to STARTUP.
- State machine:
  - STARTUP: counts BEGIN_CYCLES edges. a_prev follows the sampled a every edge, so lane transitions are ignored (no toggle, no viol, no count).
  - STARTUP→ACTIVE on the edge that completes the count; ready=1 from that edge.
  - BEGIN_CYCLES=0: ACTIVE immediately after reset release, so an a=1 already present at the first edge counts as an event.
  - ACTIVE: terminal until reset.
- Event: in ACTIVE, lane i has an event at edge k when the sampled a[i] ≠ a_prev[i].
  - Accepted if no accepted event occurred on lane i at any edge j with k−j < CT_CYCLES; otherwise dropped.
  - A dropped event still updates a_prev, so the lane resynchronises.
- Accepted event: enters the lane's LATENCY-deep delay line; q[i] toggles at edge k+LATENCY−1.
- Dropped event: viol[i] is set at edge k; q[i] is unaffected.
- viol_clr clears all viol bits at the edge where it is sampled. A new violation on the same edge wins (that bit stays 1).
- Two transitions of a[i] within one clk period cancel and are invisible. This is a documented sampling limit, not a violation.
- Lanes are fully independent; simultaneous events on several lanes are all processed.

## Timing
- All outputs are registered; there is no combinational path from a to q.
- Latency from the first sampling edge to the q toggle is LATENCY−1 further edges (LATENCY=1: q toggles on the sampling edge itself).
- Pulse throughput per lane is one accepted event per CT_CYCLES edges.
- Reset mid-operation takes effect immediately (asynchronous). After release, the full BEGIN_CYCLES hold-off restarts.

## Configuration
- PTLTX_PULSE_COUNT_EN defined:
  - Each lane keeps a CNT_W-bit counter of accepted events, saturating at all-ones.
  - Dropped events are not counted.
  - Counters clear only on rst; viol_clr does not affect them.
- Macro undefined: the pulse_cnt port and the counters are absent. All other behaviour is identical.

## Structure
- Package ptltx_pkg holds:
  - the state enum {ST_STARTUP, ST_ACTIVE};
  - width helper functions (clog2-based counter widths for BEGIN_CYCLES and CT_CYCLES).
- Parameter legality checks run at elaboration.
- Sub-module ptltx_chan contains one lane: a_prev, edge detect, guard counter, delay line, viol bit and optional counter. It is instantiated CHANNELS times under a generate loop.
- The top level holds the startup counter, the FSM, the ready flag, and the fan-out of viol_clr.

## Test plan
Defaults apply throughout: CHANNELS=4, LATENCY=3, CT_CYCLES=2, BEGIN_CYCLES=8, macro defined.
- Reset, hold a=0 → q=0 and ready=0 through edge 7; ready=1 from edge 8.
- a toggles on lanes 0/2 before edges 2 and 5 (in STARTUP) → no q change, viol=0, pulse_cnt=0, ready still rises at edge 8.
- a[0] 0→1 sampled at edge 12 and 1→0 at edge 15 → q[0] rises at 14 and falls at 17; viol[0]=0; pulse_cnt lane 0 = 2.
- a[1] toggles at edges 20 and 21 → first accepted, q[1]=1 at edge 22; second dropped, q[1] stays 1, viol[1]=1 from edge 21; lane-1 count = 1.
- viol_clr=1 on the same edge as a new lane-3 violation → viol[3] stays 1. viol_clr alone next edge → viol=0.
- rst asserted one edge after an accepted event on lane 2 → q drops to 0 asynchronously, the pending toggle never appears, ready=0, counts=0.
